// File: rtl/snn_delay_layer_param.sv
// Fully connected layer of leaky integrate-and-fire neurons with per-synapse axonal delays.
// One time step per handshake; columns are integrated sequentially, one per clock.
module snn_delay_layer_param #(
  parameter int unsigned NIn  = 8,
  parameter int unsigned NOut = 8,
  parameter int unsigned DlyW = 3,
  parameter int unsigned MpW  = 6,
  parameter int unsigned RefW = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [NIn-1:0]            in_spikes_i,
  input  logic [NOut*NIn*2-1:0]     weights_i,
  input  logic [NOut*NIn*DlyW-1:0]  delays_i,
  input  logic [MpW-2:0]            threshold_i,
  input  logic [MpW-2:0]            decay_i,
  input  logic [RefW-1:0]           refractory_period_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [NOut-1:0]           out_spikes_o,
  output logic [NOut*MpW-1:0]       membrane_potential_out_o
);

  localparam int unsigned Depth = 2 ** DlyW;
  localparam int unsigned AccW  = $clog2(NIn + 1) + 1;
  localparam int unsigned IdxW  = (NIn > 1) ? $clog2(NIn) : 1;
  localparam int unsigned CalcW = MpW + AccW + 1;
  localparam int          MpMaxI = 2 ** (MpW - 1) - 1;
  localparam logic signed [CalcW-1:0] MpMax = CalcW'(MpMaxI);
  localparam logic signed [CalcW-1:0] MpMin = CalcW'(-MpMaxI - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StUpdate, StDone} state_e;

  state_e                 state_q;
  logic                   run_q;
  logic [IdxW-1:0]        idx_q;
  logic [Depth-1:0]       hist_q [NIn];
  logic signed [AccW-1:0] acc_q  [NOut];
  logic signed [MpW-1:0]  mp_q   [NOut];
  logic [RefW-1:0]        ref_q  [NOut];
  logic [NOut-1:0]        spike_q;

  logic signed [AccW-1:0] acc_d  [NOut];
  logic signed [MpW-1:0]  mp_d   [NOut];
  logic [RefW-1:0]        ref_d  [NOut];
  logic [NOut-1:0]        spike_d;

  // run_q keeps in_ready low while reset is asserted and on the first edge after.
  assign in_ready_o   = run_q && (state_q == StIdle) && enable_i;
  assign out_valid_o  = (state_q == StDone);
  assign out_spikes_o = spike_q;

  always_comb begin
    membrane_potential_out_o = '0;
    for (int j = 0; j < int'(NOut); j++) begin
      membrane_potential_out_o[j*MpW +: MpW] = mp_q[j];
    end
  end

  // Column idx_q contribution to every neuron's accumulator.
  always_comb begin
    logic [1:0]      w;
    logic [DlyW-1:0] d;
    int unsigned     b;
    w = '0;
    d = '0;
    b = 0;
    for (int j = 0; j < int'(NOut); j++) begin
      b = j * NIn + 32'(idx_q);
      w = weights_i[b*2 +: 2];
      d = delays_i[b*DlyW +: DlyW];
      acc_d[j] = acc_q[j];
      if (hist_q[idx_q][d] && w[1]) begin
        acc_d[j] = w[0] ? acc_q[j] - AccW'(1) : acc_q[j] + AccW'(1);
      end
    end
  end

  always_comb begin
    logic signed [CalcW-1:0] mp_x, acc_x, dec_x, thr_x, leak, sum, sat;
    mp_x  = '0;
    acc_x = '0;
    leak  = '0;
    sum   = '0;
    sat   = '0;
    dec_x = CalcW'(decay_i);
    thr_x = CalcW'(threshold_i);
    spike_d = '0;
    for (int j = 0; j < int'(NOut); j++) begin
      mp_x  = {{(CalcW - MpW){mp_q[j][MpW-1]}}, mp_q[j]};
      acc_x = {{(CalcW - AccW){acc_q[j][AccW-1]}}, acc_q[j]};
      if (mp_x > dec_x) begin
        leak = mp_x - dec_x;
      end else if (mp_x < -dec_x) begin
        leak = mp_x + dec_x;
      end else begin
        leak = '0;
      end
      sum = leak + acc_x;
      if (sum > MpMax) begin
        sat = MpMax;
      end else if (sum < MpMin) begin
        sat = MpMin;
      end else begin
        sat = sum;
      end
      mp_d[j]  = sat[MpW-1:0];
      ref_d[j] = ref_q[j];
      if (ref_q[j] != '0) begin
        mp_d[j]  = '0;
        ref_d[j] = ref_q[j] - 1'b1;
      end else if (sat >= thr_x) begin
        spike_d[j] = 1'b1;
        mp_d[j]    = '0;
        ref_d[j]   = refractory_period_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      run_q   <= 1'b0;
      idx_q   <= '0;
      spike_q <= '0;
      for (int i = 0; i < int'(NIn); i++) hist_q[i] <= '0;
      for (int j = 0; j < int'(NOut); j++) begin
        acc_q[j] <= '0;
        mp_q[j]  <= '0;
        ref_q[j] <= '0;
      end
    end else begin
      run_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (in_valid_i && in_ready_o) begin
            for (int i = 0; i < int'(NIn); i++) begin
              hist_q[i] <= {hist_q[i][Depth-2:0], in_spikes_i[i]};
            end
            for (int j = 0; j < int'(NOut); j++) acc_q[j] <= '0;
            idx_q   <= '0;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          for (int j = 0; j < int'(NOut); j++) acc_q[j] <= acc_d[j];
          idx_q <= idx_q + 1'b1;
          if (idx_q == IdxW'(NIn - 1)) state_q <= StUpdate;
        end
        StUpdate: begin
          for (int j = 0; j < int'(NOut); j++) begin
            mp_q[j]  <= mp_d[j];
            ref_q[j] <= ref_d[j];
          end
          spike_q <= spike_d;
          state_q <= StDone;
        end
        StDone: begin
          if (out_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
